reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Architectural register file with rename tags. It is the receiving end of the reorder buffer's register-commit interface.
- Each register holds a value, a busy bit and the RoB tag of its newest in-flight producer.
- At issue, the decoder marks the destination register busy with the new RoB tag.
- At commit, the RoB writes the value back and clears busy only if the tag still matches.
- For source operands, the block returns either a ready value or the RoB tag to wait on. It forwards from the RoB's operand-ready lookup and from the same-cycle commit.

Parameters:
- DATA_W, 32, register value width.
- REG_W, 5, register index width (32 registers).
- ROB_W, 4, RoB tag width (16-entry RoB).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; state updates only when high.
- rollback  in  1  mispredict flush from the RoB.
- issue  in  1  one instruction with a destination register is issued this cycle.
- issue_rd  in  REG_W  destination register of the issued instruction.
- issue_rob_pos  in  ROB_W  RoB tag allocated to the issued instruction.
- commit_reg  in  1  RoB commits a register result this cycle.
- commit_reg_rd  in  REG_W  committed destination register.
- commit_reg_val  in  DATA_W  committed value.
- commit_rob_pos  in  ROB_W  RoB tag of the committing entry.
- rs1  in  REG_W  source register 1 index (decoder).
- rs2  in  REG_W  source register 2 index (decoder).
- rob_rs1_pos  out  ROB_W  tag sent to the RoB lookup port for rs1.
- rob_rs1_rdy  in  1  RoB reports that entry's result is ready.
- rob_rs1_val  in  DATA_W  RoB result for rob_rs1_pos.
- rob_rs2_pos  out  ROB_W  tag sent to the RoB lookup port for rs2.
- rob_rs2_rdy  in  1  RoB reports that entry's result is ready.
- rob_rs2_val  in  DATA_W  RoB result for rob_rs2_pos.
- rs1_has_val  out  1  rs1_val is valid and no wait is needed.
- rs1_val  out  DATA_W  operand 1 value; 0 when rs1_has_val is 0.
- rs1_dep  out  ROB_W  RoB tag to wait on; 0 when rs1_has_val is 1.
- rs2_has_val  out  1  same as rs1_has_val, for operand 2.
- rs2_val  out  DATA_W  same as rs1_val, for operand 2.
- rs2_dep  out  ROB_W  same as rs1_dep, for operand 2.

Behaviour:
- State: val[0..31], busy[0..31], tag[0..31].
- Reset (rst=1 at posedge): all val, busy and tag cleared to 0. Reset overrides rdy and all other inputs. Reset mid-operation discards all pending tags.
- Operand lookup is combinational, zero latency. Evaluation order for rs1 (rs2 is identical):
  - rob_rs1_pos = tag[rs1] always.
  - If rs1==0 or !busy[rs1]: has_val=1, val=val[rs1] (always 0 for x0).
  - Else if commit_reg && commit_reg_rd==rs1 && commit_rob_pos==tag[rs1]: has_val=1, val=commit_reg_val.
  - Else if rob_rs1_rdy: has_val=1, val=rob_rs1_val.
  - Else: has_val=0, dep=tag[rs1].
- Lookups do not see the same-cycle issue. The decoder issues the instruction whose rd is written only after its own sources are read.
- Sequential update at posedge when rdy=1 and rst=0:
  - Commit: if commit_reg && commit_reg_rd!=0, val[rd] <= commit_reg_val. If additionally busy[rd] && tag[rd]==commit_rob_pos, busy[rd] <= 0.
  - Issue: if issue && issue_rd!=0 && !rollback, busy[issue_rd] <= 1 and tag[issue_rd] <= issue_rob_pos.
  - Same register issued and committed in the same cycle: issue wins. busy stays 1 with the new tag; the value is still written.
  - Rollback: all busy <= 0; tags are don't-care. A commit in the rollback cycle still writes its value (jump-and-link commits alongside rollback). An issue in the rollback cycle is dropped.
- rdy=0: no state change; combinational outputs remain live.
- x0: never written, never busy; reads always return has_val=1, val=0.
- A stale commit (tag mismatch because a younger writer was issued) updates val but leaves busy and tag untouched.

Test Plan:
- Reset then read rs1=5, rs2=0 -> rs1_has_val=1, rs1_val=0, rs2_has_val=1, rs2_val=0.
- Issue rd=3, tag=7; next cycle read rs1=3 with rob_rs1_rdy=0 -> rob_rs1_pos=7, rs1_has_val=0, rs1_dep=7. Same read with rob_rs1_rdy=1 and rob_rs1_val=0x55 -> has_val=1, val=0x55.
- Issue rd=3 tag=2, then issue rd=3 tag=9, then commit rd=3 tag=2 val=0x11:
  - Cycle after the stale commit: val[3]=0x11, busy still 1, rs1=3 gives dep=9.
  - Commit tag=9 val=0x22 -> busy cleared, rs1_val=0x22.
- Reading rs2=4 (busy, tag 5) while commit_reg rd=4 tag=5 val=0xABCD is in the same cycle -> rs2_has_val=1, rs2_val=0xABCD before the edge.
- Busy x1 (tag 1) and x2 (tag 4); rollback=1 with commit rd=1 val=0x80 and issue rd=6 in the same cycle:
  - Next cycle: x1 reads 0x80 with has_val=1.
  - x2 has_val=1 with its old value.
  - x6 not busy.
- Issue rd=0 and commit rd=0 val=0xFF -> rs1=0 still reads has_val=1, val=0. With rdy=0, an issue of rd=8 has no effect and x8 stays not busy.

Source files
------------

// File: rtl/reg_file.sv
// Architectural register file with rename tags.
// Operand lookup forwards from the RoB and from the same-cycle commit.
module reg_file #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int ROB_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              rollback,
   input  logic              issue,
   input  logic [REG_W-1:0]  issue_rd,
   input  logic [ROB_W-1:0]  issue_rob_pos,
   input  logic              commit_reg,
   input  logic [REG_W-1:0]  commit_reg_rd,
   input  logic [DATA_W-1:0] commit_reg_val,
   input  logic [ROB_W-1:0]  commit_rob_pos,
   input  logic [REG_W-1:0]  rs1,
   input  logic [REG_W-1:0]  rs2,
   output logic [ROB_W-1:0]  rob_rs1_pos,
   input  logic              rob_rs1_rdy,
   input  logic [DATA_W-1:0] rob_rs1_val,
   output logic [ROB_W-1:0]  rob_rs2_pos,
   input  logic              rob_rs2_rdy,
   input  logic [DATA_W-1:0] rob_rs2_val,
   output logic              rs1_has_val,
   output logic [DATA_W-1:0] rs1_val,
   output logic [ROB_W-1:0]  rs1_dep,
   output logic              rs2_has_val,
   output logic [DATA_W-1:0] rs2_val,
   output logic [ROB_W-1:0]  rs2_dep
);

   localparam int NREG = 1 << REG_W;

   typedef struct packed {
      logic              has;
      logic [DATA_W-1:0] val;
      logic [ROB_W-1:0]  dep;
   } opnd_t;

   logic [DATA_W-1:0] val_q  [NREG];
   logic [ROB_W-1:0]  tag_q  [NREG];
   logic [NREG-1:0]   busy_q;

   opnd_t op1;
   opnd_t op2;

   function automatic opnd_t lookup(
      input logic [REG_W-1:0]  rs,
      input logic              rob_rdy,
      input logic [DATA_W-1:0] rob_val
   );
      opnd_t o;
      o = '0;
      if (rs == '0 || !busy_q[rs]) begin
         o.has = 1'b1;
         o.val = val_q[rs];
      end else if (commit_reg && commit_reg_rd == rs &&
                   commit_rob_pos == tag_q[rs]) begin
         o.has = 1'b1;
         o.val = commit_reg_val;
      end else if (rob_rdy) begin
         o.has = 1'b1;
         o.val = rob_val;
      end else begin
         o.dep = tag_q[rs];
      end
      return o;
   endfunction

   // Resolve both source operands: own value, commit bypass, RoB, or wait.
   always_comb begin
      rob_rs1_pos = tag_q[rs1];
      rob_rs2_pos = tag_q[rs2];
      op1 = lookup(rs1, rob_rs1_rdy, rob_rs1_val);
      op2 = lookup(rs2, rob_rs2_rdy, rob_rs2_val);
      rs1_has_val = op1.has;
      rs1_val     = op1.val;
      rs1_dep     = op1.dep;
      rs2_has_val = op2.has;
      rs2_val     = op2.val;
      rs2_dep     = op2.dep;
   end

   // Commit writes value; rollback clears busy; issue (last) wins on busy/tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         for (int i = 0; i < NREG; i++) begin
            val_q[i] <= '0;
            tag_q[i] <= '0;
         end
      end else if (rdy) begin
         if (commit_reg && commit_reg_rd != '0) begin
            val_q[commit_reg_rd] <= commit_reg_val;
            if (busy_q[commit_reg_rd] &&
                tag_q[commit_reg_rd] == commit_rob_pos)
               busy_q[commit_reg_rd] <= 1'b0;
         end
         if (rollback)
            busy_q <= '0;
         if (issue && issue_rd != '0 && !rollback) begin
            busy_q[issue_rd] <= 1'b1;
            tag_q[issue_rd]  <= issue_rob_pos;
         end
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file.
// Inputs change 1ns after a rising edge; outputs are checked before the next.
module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst, rdy, rollback, issue, commit_reg;
   logic [4:0]  issue_rd, commit_reg_rd, rs1, rs2;
   logic [3:0]  issue_rob_pos, commit_rob_pos;
   logic [31:0] commit_reg_val, rob_rs1_val, rob_rs2_val;
   logic        rob_rs1_rdy, rob_rs2_rdy;
   logic [3:0]  rob_rs1_pos, rob_rs2_pos, rs1_dep, rs2_dep;
   logic        rs1_has_val, rs2_has_val;
   logic [31:0] rs1_val, rs2_val;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   reg_file dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
      .commit_reg(commit_reg), .commit_reg_rd(commit_reg_rd),
      .commit_reg_val(commit_reg_val), .commit_rob_pos(commit_rob_pos),
      .rs1(rs1), .rs2(rs2),
      .rob_rs1_pos(rob_rs1_pos), .rob_rs1_rdy(rob_rs1_rdy),
      .rob_rs1_val(rob_rs1_val),
      .rob_rs2_pos(rob_rs2_pos), .rob_rs2_rdy(rob_rs2_rdy),
      .rob_rs2_val(rob_rs2_val),
      .rs1_has_val(rs1_has_val), .rs1_val(rs1_val), .rs1_dep(rs1_dep),
      .rs2_has_val(rs2_has_val), .rs2_val(rs2_val), .rs2_dep(rs2_dep)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_issue(input logic [4:0] rd, input logic [3:0] t);
      issue = 1'b1; issue_rd = rd; issue_rob_pos = t;
      step();
      issue = 1'b0;
   endtask

   task automatic do_commit(input logic [4:0] rd, input logic [3:0] t,
                            input logic [31:0] v);
      commit_reg = 1'b1; commit_reg_rd = rd;
      commit_rob_pos = t; commit_reg_val = v;
      step();
      commit_reg = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; rollback = 1'b0; issue = 1'b0;
      commit_reg = 1'b0; issue_rd = '0; commit_reg_rd = '0;
      rs1 = '0; rs2 = '0; issue_rob_pos = '0; commit_rob_pos = '0;
      commit_reg_val = '0; rob_rs1_val = '0; rob_rs2_val = '0;
      rob_rs1_rdy = 1'b0; rob_rs2_rdy = 1'b0;
      step(); step();
      rst = 1'b0;

      // Reset state
      rs1 = 5'd5; rs2 = 5'd0; #1;
      check("rst_rs1_has", 32'(rs1_has_val), 32'd1);
      check("rst_rs1_val", rs1_val, 32'd0);
      check("rst_rs1_dep", 32'(rs1_dep), 32'd0);
      check("rst_rs2_has", 32'(rs2_has_val), 32'd1);
      check("rst_rs2_val", rs2_val, 32'd0);

      // Busy register waits on its tag, or takes the RoB value
      do_issue(5'd3, 4'd7);
      rs1 = 5'd3; #1;
      check("busy_pos", 32'(rob_rs1_pos), 32'd7);
      check("busy_has", 32'(rs1_has_val), 32'd0);
      check("busy_dep", 32'(rs1_dep), 32'd7);
      check("busy_val0", rs1_val, 32'd0);
      rob_rs1_rdy = 1'b1; rob_rs1_val = 32'h55; #1;
      check("robfw_has", 32'(rs1_has_val), 32'd1);
      check("robfw_val", rs1_val, 32'h55);
      check("robfw_dep", 32'(rs1_dep), 32'd0);
      rob_rs1_rdy = 1'b0; rob_rs1_val = '0;

      // Stale commit keeps busy and newer tag
      do_issue(5'd3, 4'd2);
      do_issue(5'd3, 4'd9);
      commit_reg = 1'b1; commit_reg_rd = 5'd3;
      commit_rob_pos = 4'd2; commit_reg_val = 32'h11; #1;
      check("stale_nofw", 32'(rs1_has_val), 32'd0);
      step();
      commit_reg = 1'b0; #1;
      check("stale_has", 32'(rs1_has_val), 32'd0);
      check("stale_dep", 32'(rs1_dep), 32'd9);
      do_commit(5'd3, 4'd9, 32'h22);
      check("commit_has", 32'(rs1_has_val), 32'd1);
      check("commit_val", rs1_val, 32'h22);

      // Same-cycle commit bypass on rs2
      do_issue(5'd4, 4'd5);
      rs2 = 5'd4;
      commit_reg = 1'b1; commit_reg_rd = 5'd4;
      commit_rob_pos = 4'd5; commit_reg_val = 32'hABCD; #1;
      check("byp_pos", 32'(rob_rs2_pos), 32'd5);
      check("byp_has", 32'(rs2_has_val), 32'd1);
      check("byp_val", rs2_val, 32'hABCD);
      step();
      commit_reg = 1'b0; #1;
      check("byp_after", rs2_val, 32'hABCD);

      // Rollback with commit and dropped issue
      do_commit(5'd2, 4'd0, 32'h1234);
      do_issue(5'd1, 4'd1);
      do_issue(5'd2, 4'd4);
      rollback = 1'b1;
      commit_reg = 1'b1; commit_reg_rd = 5'd1;
      commit_rob_pos = 4'd1; commit_reg_val = 32'h80;
      issue = 1'b1; issue_rd = 5'd6; issue_rob_pos = 4'd3;
      step();
      rollback = 1'b0; commit_reg = 1'b0; issue = 1'b0;
      rs1 = 5'd1; rs2 = 5'd2; #1;
      check("rb_x1_has", 32'(rs1_has_val), 32'd1);
      check("rb_x1_val", rs1_val, 32'h80);
      check("rb_x2_has", 32'(rs2_has_val), 32'd1);
      check("rb_x2_val", rs2_val, 32'h1234);
      rs1 = 5'd6; #1;
      check("rb_x6_has", 32'(rs1_has_val), 32'd1);

      // Stale value survives and shows once rollback clears busy
      do_issue(5'd7, 4'd2);
      do_issue(5'd7, 4'd9);
      do_commit(5'd7, 4'd2, 32'h11);
      rollback = 1'b1; step(); rollback = 1'b0;
      rs1 = 5'd7; #1;
      check("stale_val", rs1_val, 32'h11);

      // x0 is never written or busy
      issue = 1'b1; issue_rd = 5'd0; issue_rob_pos = 4'd3;
      commit_reg = 1'b1; commit_reg_rd = 5'd0;
      commit_rob_pos = 4'd3; commit_reg_val = 32'hFF;
      rs1 = 5'd0; #1;
      check("x0_byp_val", rs1_val, 32'd0);
      step();
      issue = 1'b0; commit_reg = 1'b0; #1;
      check("x0_has", 32'(rs1_has_val), 32'd1);
      check("x0_val", rs1_val, 32'd0);

      // rdy low freezes state
      rdy = 1'b0;
      do_issue(5'd8, 4'd6);
      do_commit(5'd3, 4'd0, 32'h99);
      rdy = 1'b1;
      rs1 = 5'd8; rs2 = 5'd3; #1;
      check("rdy_x8_has", 32'(rs1_has_val), 32'd1);
      check("rdy_x3_val", rs2_val, 32'h22);

      // Reset mid-operation clears busy and values
      do_issue(5'd9, 4'd5);
      rst = 1'b1; step(); rst = 1'b0;
      rs1 = 5'd9; rs2 = 5'd3; #1;
      check("rst2_x9_has", 32'(rs1_has_val), 32'd1);
      check("rst2_x9_pos", 32'(rob_rs1_pos), 32'd0);
      check("rst2_x3_val", rs2_val, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
